// File: rtl/mem_arb_pkg.sv
// Shared FSM encoding and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned BW_DEF = 16;
  localparam int unsigned AW_DEF = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester A/B handshake and single-port memory bus for mem_arb.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned BW = BW_DEF,
  parameter int unsigned AW = AW_DEF
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [BW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [BW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [BW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [BW-1:0] b_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [BW-1:0] mem_dout;
  logic [BW-1:0] mem_din;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_we, mem_dout,
    input  mem_din
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_we, mem_dout,
    output mem_din
  );
endinterface

// File: rtl/mem_arb_pick2.sv
// Two-way winner selection; last=1 means requester B was granted most recently.
module arb_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic pick_a,
  output logic pick_b
);
  assign pick_a = req_a & (~req_b | last);
  assign pick_b = req_b & (~req_a | ~last);
endmodule

// File: rtl/mem_arb.sv
// Arbiter granting A/B one access per two cycles to a sync-read memory.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise A wins every tie.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned BW = BW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);

  state_t        r_state;
  state_t        w_next;
  logic          w_pick_a;
  logic          w_pick_b;
  logic          w_last;
  logic          w_take;
  logic [AW-1:0] r_addr;
  logic [BW-1:0] r_wdata;
  logic          r_we;
  logic          r_rv_a;
  logic          r_rv_b;

  arb_pick2 u_pick (
    .req_a  (bus.a_req),
    .req_b  (bus.b_req),
    .last   (w_last),
    .pick_a (w_pick_a),
    .pick_b (w_pick_b)
  );

  assign w_take = (r_state == IDLE) && (w_pick_a || w_pick_b);

`ifdef MEM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (!rst)        r_last <= 1'b1;
    else if (w_take) r_last <= w_pick_b;
  end

  assign w_last = r_last;
`else
  // Pinning the pointer at "B last" turns the round-robin picker into fixed A priority.
  assign w_last = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_a)      w_next = GNT_A;
        else if (w_pick_b) w_next = GNT_B;
      end
      GNT_A, GNT_B: w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rv_a  <= 1'b0;
      r_rv_b  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rv_a  <= (r_state == GNT_A) && !r_we;
      r_rv_b  <= (r_state == GNT_B) && !r_we;
      if (w_take) begin
        r_addr  <= w_pick_a ? bus.a_addr  : bus.b_addr;
        r_wdata <= w_pick_a ? bus.a_wdata : bus.b_wdata;
        r_we    <= w_pick_a ? bus.a_we    : bus.b_we;
      end
    end
  end

  // Captured address/data stay on the memory bus between grants; only we is gated.
  assign bus.mem_addr = r_addr;
  assign bus.mem_dout = r_wdata;
  assign bus.mem_we   = r_we && (r_state != IDLE);

  assign bus.a_gnt    = (r_state == GNT_A);
  assign bus.b_gnt    = (r_state == GNT_B);
  assign bus.a_rvalid = r_rv_a;
  assign bus.b_rvalid = r_rv_b;
  assign bus.a_rdata  = bus.mem_din;
  assign bus.b_rdata  = bus.mem_din;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed cases plus randomized traffic vs. a cycle model.
module tb_mem_arb;
  localparam int BW = 16;
  localparam int AW = 9;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.BW(BW), .AW(AW)) bus ();
  mem_arb #(.BW(BW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [BW-1:0] init_val(int unsigned i);
    if (i == 511) return 16'hBEEF;
    return BW'((i * 32'h3A5) ^ 32'h5C);
  endfunction

  // Memory environment: single port, synchronous read.
  logic [BW-1:0] mem    [0:DEPTH-1];
  logic [BW-1:0] shadow [0:DEPTH-1];
  logic [BW-1:0] mem_q;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = init_val(i);
      shadow[i] = init_val(i);
    end
  end

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_dout;
    mem_q <= mem[bus.mem_addr];
  end
  assign bus.mem_din = mem_q;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one grant per two cycles, result of a read one cycle after its grant.
  bit            m_valid = 0;
  bit            m_lastb = 1;
  logic          e_ga = 0, e_gb = 0, e_rva = 0, e_rvb = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [BW-1:0] e_dout = '0, e_rdata = '0;

  always @(posedge clk) begin
    bit wa, wb;
    if (m_valid && e_we) shadow[e_addr] = e_dout;
    if (!rst) begin
      m_valid = 1;
      m_lastb = 1;
      e_ga = 0; e_gb = 0; e_rva = 0; e_rvb = 0; e_we = 0;
      e_addr = '0; e_dout = '0;
    end else if (m_valid) begin
      e_rva = e_ga && !e_we;
      e_rvb = e_gb && !e_we;
      if (e_rva || e_rvb) e_rdata = shadow[e_addr];
      wa = 0; wb = 0;
      if (!(e_ga || e_gb)) begin
        if (bus.a_req && bus.b_req) begin
`ifdef MEM_ARB_RR_EN
          wa = m_lastb; wb = !m_lastb;
`else
          wa = 1;
`endif
        end else begin
          wa = bus.a_req; wb = bus.b_req;
        end
      end
      e_ga = wa; e_gb = wb;
      if (wa) begin
        e_addr = bus.a_addr; e_dout = bus.a_wdata; e_we = bus.a_we;
      end else if (wb) begin
        e_addr = bus.b_addr; e_dout = bus.b_wdata; e_we = bus.b_we;
      end else begin
        e_we = 0;
      end
      if (wa || wb) m_lastb = wb;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("a_gnt", bus.a_gnt, e_ga);
      cmp("b_gnt", bus.b_gnt, e_gb);
      cmp("a_rvalid", bus.a_rvalid, e_rva);
      cmp("b_rvalid", bus.b_rvalid, e_rvb);
      cmp("mem_we", bus.mem_we, e_we);
      cmp("mem_addr", bus.mem_addr, e_addr);
      cmp("mem_dout", bus.mem_dout, e_dout);
      cmp("gnt_excl", bus.a_gnt & bus.b_gnt, 0);
      cmp("rvalid_excl", bus.a_rvalid & bus.b_rvalid, 0);
      if (e_rva) cmp("a_rdata", bus.a_rdata, e_rdata);
      if (e_rvb) cmp("b_rdata", bus.b_rdata, e_rdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] wd);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] wd);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
  endtask

  initial begin
    logic [7:0] pat_a, pat_b;
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    rst = 0;
    repeat (3) tick();
    cmp("rst_a_gnt", bus.a_gnt, 0);
    cmp("rst_b_gnt", bus.b_gnt, 0);
    cmp("rst_mem_we", bus.mem_we, 0);
    cmp("rst_mem_addr", bus.mem_addr, 0);
    cmp("rst_mem_dout", bus.mem_dout, 0);
    rst = 1;
    tick();
    cmp("post_rst_no_gnt", bus.a_gnt | bus.b_gnt, 0);

    // A-only write
    set_a(1, 1, 9'h005, 16'h1234);
    tick();
    cmp("wr_a_gnt", bus.a_gnt, 1);
    cmp("wr_b_gnt", bus.b_gnt, 0);
    cmp("wr_mem_we", bus.mem_we, 1);
    cmp("wr_mem_addr", bus.mem_addr, 9'h005);
    cmp("wr_mem_dout", bus.mem_dout, 16'h1234);
    set_a(0, 0, '0, '0);
    tick();
    cmp("wr_gnt_drop", bus.a_gnt, 0);
    cmp("wr_we_drop", bus.mem_we, 0);
    cmp("wr_addr_hold", bus.mem_addr, 9'h005);

    // B-only read
    set_b(1, 0, 9'h1FF, '0);
    tick();
    cmp("rd_b_gnt", bus.b_gnt, 1);
    cmp("rd_mem_we", bus.mem_we, 0);
    cmp("rd_mem_addr", bus.mem_addr, 9'h1FF);
    set_b(0, 0, '0, '0);
    tick();
    cmp("rd_b_rvalid", bus.b_rvalid, 1);
    cmp("rd_b_rdata", bus.b_rdata, 16'hBEEF);
    cmp("rd_mem_we2", bus.mem_we, 0);

    // Continuous contention from reset
    rst = 0;
    tick();
    tick();
    rst = 1;
    set_a(1, 0, 9'h010, '0);
    set_b(1, 0, 9'h020, '0);
    pat_a = '0; pat_b = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat_a[i] = bus.a_gnt;
      pat_b[i] = bus.b_gnt;
    end
`ifdef MEM_ARB_RR_EN
    cmp("tie_pat_a", pat_a, 8'b0001_0001);
    cmp("tie_pat_b", pat_b, 8'b0100_0100);
`else
    cmp("tie_pat_a", pat_a, 8'b0101_0101);
    cmp("tie_pat_b", pat_b, 8'b0000_0000);
`endif
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    tick();
    tick();

    // Reset during a GNT_B read
    set_b(1, 0, 9'h033, '0);
    tick();
    cmp("abort_b_gnt", bus.b_gnt, 1);
    rst = 0;
    set_b(0, 0, '0, '0);
    tick();
    cmp("abort_gnt", bus.a_gnt | bus.b_gnt, 0);
    cmp("abort_rvalid", bus.a_rvalid | bus.b_rvalid, 0);
    cmp("abort_mem_we", bus.mem_we, 0);
    cmp("abort_mem_addr", bus.mem_addr, 0);
    rst = 1;
    tick();
    cmp("abort_no_rvalid", bus.b_rvalid, 0);

    // A request arriving during GNT_B
    set_b(1, 0, 9'h044, '0);
    tick();
    cmp("late_b_gnt", bus.b_gnt, 1);
    set_b(0, 0, '0, '0);
    set_a(1, 0, 9'h055, '0);
    tick();
    cmp("late_a_not_yet", bus.a_gnt, 0);
    tick();
    cmp("late_a_gnt", bus.a_gnt, 1);
    set_a(0, 0, '0, '0);
    tick();
    tick();

    // Random traffic following the hold-until-grant protocol
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if (!bus.a_req || bus.a_gnt) begin
        if ($urandom_range(0, 3) != 0)
          set_a(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), BW'($urandom));
        else
          set_a(0, 0, '0, '0);
      end
      if (!bus.b_req || bus.b_gnt) begin
        if ($urandom_range(0, 3) != 0)
          set_b(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), BW'($urandom));
        else
          set_b(0, 0, '0, '0);
      end
    end
    rst = 1;
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter BW, default 16, data width in bits.
REQ-002 SHALL have parameter AW, default 9, memory address width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports a_req, a_we  input  1 each  requester A (CPU) request and write-enable.
REQ-006 SHALL have ports a_addr  input  AW  and  a_wdata  input  BW  for requester A.
REQ-007 SHALL have ports a_gnt, a_rvalid  output  1 each  and  a_rdata  output  BW  for requester A.
REQ-008 SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata for requester B (host loader), with widths and directions identical to A.
REQ-009 SHALL have ports mem_addr  output  AW,  mem_we  output  1,  mem_dout  output  BW  and  mem_din  input  BW  to the single-port synchronous-read memory.

Function
REQ-010 SHALL implement the FSM states IDLE, GNT_A and GNT_B.
REQ-011 SHALL, in IDLE, sample a_req and b_req at the rising edge and move to GNT_A or GNT_B per the arbitration rule; with no request it SHALL stay in IDLE.
REQ-012 SHALL spend exactly one cycle in GNT_x and then return to IDLE unconditionally; requests SHALL be ignored while in GNT_x.
REQ-013 SHALL give at most one grant every 2 cycles.
REQ-014 SHALL, in GNT_x, assert x_gnt for exactly that one cycle, with the registered copies of x_addr, x_we and x_wdata on mem_addr, mem_we and mem_dout.
REQ-015 SHALL require each requester to hold req, we, addr and wdata stable until it sees gnt, and to drop req, or present a new transaction, on the next cycle.
REQ-016 SHALL, for a read granted in cycle N, assert x_rvalid for exactly one cycle in cycle N+1 with x_rdata = mem_din; otherwise x_rdata SHALL be don't-care.
REQ-017 SHALL keep mem_we high only in a GNT_x cycle whose captured we=1; mem_we SHALL be 0 at all other times.
REQ-018 SHALL hold mem_addr and mem_dout at their last values outside GNT_x.
REQ-019 SHALL grant a single requester immediately from IDLE.
REQ-020 SHALL, when both requesters request in the same IDLE cycle, resolve them per REQ-026 and REQ-027.
REQ-021 SHALL keep a losing request pending and grant it after the following IDLE cycle.
REQ-022 SHALL never assert a_gnt and b_gnt simultaneously, nor a_rvalid and b_rvalid simultaneously.

Reset
REQ-023 SHALL, while rst=0 at a rising edge, set the state to IDLE and clear a_gnt, b_gnt, a_rvalid, b_rvalid and mem_we; mem_addr and mem_dout SHALL be 0; the round-robin pointer SHALL point to "B last granted".
REQ-024 SHALL, when reset is asserted during GNT_x, abort the transaction and suppress its rvalid in the following cycle.
REQ-025 SHALL make no grant in the first cycle after rst returns to 1 unless a request is sampled at that edge.

Configuration
REQ-026 SHALL, with MEM_ARB_RR_EN defined, use two-way round-robin: on a tie, grant the requester not granted last; the pointer updates on every grant.
REQ-027 SHALL, without MEM_ARB_RR_EN, use fixed priority with A winning every tie and no pointer register; B can starve.

Structure
REQ-028 SHALL place the state encoding (IDLE, GNT_A, GNT_B) and the BW/AW default constants in the shared package mem_arb_pkg.
REQ-029 SHALL implement winner selection as one combinational sub-module arb_pick2, taking req_a, req_b and last and producing pick_a and pick_b.

Verification
REQ-030 SHALL cover: A-only write, a_addr=0x005, a_wdata=0x1234 -> a_gnt high 1 cycle with mem_we=1, mem_addr=0x005, mem_dout=0x1234; no b_gnt.
REQ-031 SHALL cover: B-only read, b_addr=0x1FF, memory returns 0xBEEF -> b_gnt in cycle N, b_rvalid in N+1 with b_rdata=0xBEEF, mem_we=0 throughout.
REQ-032 SHALL cover: A and B requesting continuously for 8 cycles, RR enabled -> grants alternate A,B,A,B (A first after reset), 4 grants total, one every 2 cycles.
REQ-033 SHALL cover: the same stimulus with the macro undefined -> 4 grants, all to A; b_gnt never asserts.
REQ-034 SHALL cover: rst=0 asserted in a GNT_B read cycle -> next cycle all gnt/rvalid=0, mem_we=0, mem_addr=0, state IDLE; no b_rvalid.
REQ-035 SHALL cover: A request arriving in the GNT_B cycle -> not granted that cycle; a_gnt asserted 2 cycles later.
